// File: rtl/bus_sequencer_if.sv
// Microinstruction, register-bus and memory handshake bundle for bus_sequencer.
// The master side offers microinstructions and answers memory requests.
interface bus_sequencer_if #(
  parameter int NUM_SRC = 9,
  parameter int NUM_DST = 9
);
  logic               uinst_valid;
  logic               uinst_ready;
  logic [3:0]         b_sel;
  logic [NUM_DST-1:0] c_mask;
  logic [1:0]         mem_op;
  logic [NUM_SRC-1:0] b_read_enable;
  logic [NUM_DST-1:0] c_write_enable;
  logic               mem_rd;
  logic               mem_wr;
  logic               mem_fetch;
  logic               mem_ack;
  logic               err;
  logic               err_clear;
  logic               busy;

  modport master (
    output uinst_valid, b_sel, c_mask, mem_op, mem_ack, err_clear,
    input  uinst_ready, b_read_enable, c_write_enable,
           mem_rd, mem_wr, mem_fetch, err, busy
  );

  modport slave (
    input  uinst_valid, b_sel, c_mask, mem_op, mem_ack, err_clear,
    output uinst_ready, b_read_enable, c_write_enable,
           mem_rd, mem_wr, mem_fetch, err, busy
  );
endinterface

// File: rtl/bus_sequencer.sv
// Microinstruction sequencer: drives one B-bus source, writes C-bus destinations,
// then optionally issues one memory request and waits for its ack or a timeout.
module bus_sequencer #(
  parameter int NUM_SRC     = 9,
  parameter int NUM_DST     = 9,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           reset,
  bus_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    MEM   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_DST-1:0] c_mask_q, c_mask_d;
  logic [1:0]         mem_op_q, mem_op_d;
  logic               bad_sel_q, bad_sel_d;

  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               fetch_q, fetch_d;
  logic [NUM_SRC-1:0] b_en_q, b_en_d;
  logic [NUM_DST-1:0] c_we_q, c_we_d;
  logic               err_set;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c_mask_d  = c_mask_q;
    mem_op_d  = mem_op_q;
    bad_sel_d = bad_sel_q;
    b_en_d    = '0;
    c_we_d    = '0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    fetch_d   = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      IDLE: begin
        // ready_q is low for the first cycle after reset, so nothing is taken then
        if (ready_q && bus.uinst_valid) begin
          state_d   = DRIVE;
          c_mask_d  = bus.c_mask;
          mem_op_d  = bus.mem_op;
          bad_sel_d = (32'(bus.b_sel) >= NUM_SRC);
          b_en_d    = (32'(bus.b_sel) < NUM_SRC) ? (NUM_SRC'(1) << bus.b_sel) : '0;
        end
      end
      DRIVE: begin
        state_d = WRITE;
        b_en_d  = b_en_q;
        c_we_d  = c_mask_q;
        err_set = bad_sel_q;
      end
      WRITE: begin
        if (mem_op_q == 2'b00) begin
          state_d = IDLE;
        end else begin
          state_d = MEM;
          cnt_d   = 8'd0;
          rd_d    = (mem_op_q == 2'b01);
          wr_d    = (mem_op_q == 2'b10);
          fetch_d = (mem_op_q == 2'b11);
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    // a new error event outranks a simultaneous clear
    err_d   = err_set | (err_q & ~bus.err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      c_mask_q  <= '0;
      mem_op_q  <= 2'b00;
      bad_sel_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      fetch_q   <= 1'b0;
      b_en_q    <= '0;
      c_we_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_mask_q  <= c_mask_d;
      mem_op_q  <= mem_op_d;
      bad_sel_q <= bad_sel_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      fetch_q   <= fetch_d;
      b_en_q    <= b_en_d;
      c_we_q    <= c_we_d;
    end
  end

  assign bus.uinst_ready    = ready_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_wr         = wr_q;
  assign bus.mem_fetch      = fetch_q;
  assign bus.b_read_enable  = b_en_q;
  assign bus.c_write_enable = c_we_q;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter NUM_SRC, default 9: number of B-bus source registers (one read enable each).
REQ-002 Parameter NUM_DST, default 9: number of C-bus destination registers (one write enable each).
REQ-003 Parameter MEM_TIMEOUT, default 8: maximum cycles to wait for mem_ack; legal range 2..255.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 uinst_valid  in  1  a microinstruction is offered.
REQ-007 uinst_ready  out  1  the sequencer accepts a microinstruction this cycle.
REQ-008 b_sel  in  4  encoded B-bus source index.
REQ-009 c_mask  in  NUM_DST  C-bus destination write mask; multiple bits allowed.
REQ-010 mem_op  in  2  memory operation: 00 none, 01 read, 10 write, 11 fetch.
REQ-011 b_read_enable  out  NUM_SRC  one-hot B-bus source enable.
REQ-012 c_write_enable  out  NUM_DST  C-bus destination write enables.
REQ-013 mem_rd / mem_wr / mem_fetch  out  1 each  single-cycle memory request strobes.
REQ-014 mem_ack  in  1  memory completion; sampled only in MEM.
REQ-015 err  out  1  sticky error flag: timeout or illegal b_sel.
REQ-016 err_clear  in  1  synchronous clear of err.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, DRIVE, WRITE, MEM. All outputs are decoded from registered state and latched fields (Moore), with no combinational path from inputs to outputs except uinst_ready.
REQ-019 IDLE: uinst_ready=1. When uinst_valid=1 at a posedge, the sequencer latches b_sel, c_mask and mem_op and moves to DRIVE.
REQ-020 DRIVE (exactly 1 cycle): b_read_enable = 1 << latched b_sel. If b_sel >= NUM_SRC, b_read_enable is all zeros and err is set at the DRIVE->WRITE edge. Next state is WRITE unconditionally.
REQ-021 WRITE (exactly 1 cycle): c_write_enable = latched c_mask, and b_read_enable is held at its DRIVE value so the source keeps driving the bus while the destination captures it. If mem_op=00, next state is IDLE; otherwise next state is MEM.
REQ-022 MEM: in the first MEM cycle, exactly one strobe matching mem_op is high; in later cycles all strobes are low. b_read_enable and c_write_enable are zero.
REQ-023 MEM wait counter: 8-bit, cleared on MEM entry, incremented each MEM cycle that mem_ack=0.
REQ-024 If mem_ack=1 in any MEM cycle, including the strobe cycle, next state is IDLE.
REQ-025 If the counter reaches MEM_TIMEOUT-1 with mem_ack=0, next state is IDLE and err is set.
REQ-026 Latency: for an instruction accepted at edge k (k+1 is the next edge):
  - DRIVE occupies k..k+1 and WRITE occupies k+1..k+2.
  - With mem_op=00, uinst_ready is high again after edge k+2, giving one instruction per 3 cycles.
REQ-027 uinst_ready is low from DRIVE through MEM. Inputs are ignored in those states, and there is no back-to-back acceptance.
REQ-028 c_mask=0 is legal: no write occurs and the state timing is unchanged.
REQ-029 err priority: if err_clear and a new error event occur in the same cycle, err=1 (set wins).
REQ-030 mem_ack seen outside MEM is ignored and does not affect err.

Reset
REQ-031 When reset is asserted, the block SHALL immediately (asynchronously) force:
  - state IDLE, counter 0, latched fields 0;
  - b_read_enable=0, c_write_enable=0, all strobes 0;
  - err=0, busy=0, uinst_ready=0 while reset is high.
REQ-032 A reset asserted mid-operation (DRIVE, WRITE or MEM) SHALL abort the operation, with no strobe or enable pulse emitted afterward.
REQ-033 After reset deasserts, uinst_ready=1 on the first posedge-stable cycle.

Verification
REQ-034 The bench SHALL cover these scenarios:
  - b_sel=3, c_mask=0x005, mem_op=00 → b_read_enable=0x008 for 2 cycles (DRIVE, WRITE), c_write_enable=0x005 for 1 cycle, uinst_ready high 3 cycles after acceptance.
  - mem_op=01, mem_ack at MEM cycle 3 → mem_rd high for exactly 1 cycle, busy high for 5 cycles total, err=0.
  - mem_op=10, no mem_ack, MEM_TIMEOUT=8 → mem_wr pulses once, return to IDLE after 8 MEM cycles, err=1; err_clear → err=0 next cycle.
  - b_sel=12 (NUM_SRC=9) → b_read_enable=0 in DRIVE, err=1, c_write_enable still pulses with c_mask.
  - reset asserted in the MEM strobe cycle → all outputs 0 immediately, no strobe after release, uinst_ready=1.
  - uinst_valid held high continuously with mem_op=00 → exactly one acceptance every 3 cycles; mem_ack pulsed in IDLE has no effect.
